frac_mul_sched: RTL
===================

Name: frac_mul_sched

Overview:
- Round-robin scheduler sharing one iterative 8x16 shift-add fractional multiplier among NUM_REQ requesters.
- Typical requesters are the quantization/scaling lanes of the compression pipeline.
- Operands are an unsigned integer a (A_W bits) and a Q0.B_W fraction b. The result is Q(A_W).(B_W), returned with the requester ID.
- One multiply is in flight at a time. It processes one multiplier bit per cycle.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- A_W, 8, integer operand width; also the number of iteration cycles.
- B_W, 16, fraction operand width (Q0.B_W).
- ID_W, 2, requester ID width; must equal clog2(NUM_REQ).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req_valid  input  NUM_REQ  per-requester operand valid.
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  input  NUM_REQ*A_W  packed integer operands; requester i at [i*A_W +: A_W].
- req_b  input  NUM_REQ*B_W  packed fraction operands; requester i at [i*B_W +: B_W].
- res_valid  output  1  result valid.
- res_ready  input  1  result consumer ready.
- res_p  output  A_W+B_W  product a*b, Q(A_W).(B_W).
- res_id  output  ID_W  index of the requester that owns res_p.
- busy  output  1  high in MUL or HOLD.

Behaviour:
- Reset (async assert, sync deassert expected upstream). All outputs go to 0. State goes to IDLE. The priority pointer is set so requester 0 has highest priority.
- FSM states: IDLE, MUL, HOLD.
- IDLE:
  - req_ready[g] = 1 combinationally for the winner g only.
  - g is the first requester with req_valid=1, searching from (last_grant+1) mod NUM_REQ upward with wrap.
  - No valid requests: req_ready = 0 and the FSM stays in IDLE.
  - On handshake (req_valid[g] & req_ready[g] at a rising edge): latch a_reg, b_reg (zero-extended to A_W+B_W), acc=0, cnt=0, res_id=g, last_grant=g; go to MUL.
- MUL, each cycle:
  - If a_reg[0]: acc <= acc + b_reg.
  - Then a_reg >>= 1, b_reg <<= 1, cnt++.
  - After exactly A_W MUL cycles (cnt reaches A_W-1 and that cycle completes), go to HOLD.
  - No early termination; latency is fixed regardless of operand values.
  - req_ready = 0 throughout.
- HOLD:
  - res_valid = 1; res_p = acc and res_id are held stable.
  - On res_valid & res_ready at a rising edge: res_valid -> 0 and the FSM goes to IDLE.
  - res_ready low holds the state indefinitely; no new request is accepted.
- Latency: accept edge T; res_valid is high from edge T+A_W onward.
- Minimum issue interval is A_W+2 cycles: 1 IDLE + A_W MUL + 1 HOLD, with res_ready tied high.
- Arithmetic:
  - Exact unsigned product.
  - The accumulator is A_W+B_W bits and cannot overflow, since (2^A_W-1)(2^B_W-1) < 2^(A_W+B_W).
  - No rounding or truncation.
- Fairness: a requester that holds valid is granted within NUM_REQ grants.
- Requester rules:
  - Must hold req_a/req_b stable while req_valid is high and req_ready is low.
  - May deassert req_valid before a grant without error.
  - The grant decision samples valid in the same cycle only; no grant is remembered across cycles.
- Reset mid-MUL or mid-HOLD: the operation is discarded and no result is produced. After reset, requester 0 again has first priority.
- Boundary cases:
  - a=0 or b=0 still takes A_W cycles and yields 0.
  - A single requester asserting continuously is served back-to-back every A_W+2 cycles.
- Outputs res_p/res_id are registered. req_ready is combinational from req_valid and state.

Test Plan:
- Single op, requester 2: a=8'd255, b=16'hFFFF, res_ready=1 -> res_valid at accept+8 cycles, res_p=24'hFEFF01, res_id=2; req_ready stays 0 until return to IDLE.
- Fraction check, requester 0: a=3, b=16'h8000 (0.5) -> res_p=24'h018000 (1.5). Then a=0, b=16'h1234 -> res_p=0 after the full 8 cycles.
- Arbitration: all four requesters hold valid with distinct operands after reset -> grant order 0,1,2,3,0. Each result matches a_i*b_i with the correct res_id. Accepts are spaced 10 cycles apart.
- Backpressure: hold res_ready=0 for 5 cycles in HOLD -> res_valid, res_p and res_id stable; no req_ready while req_valid is asserted. res_ready=1 -> exactly one result, then the next grant.
- Reset mid-MUL: deassert rst_n 4 cycles after accept -> immediately all outputs 0 and no result. After release, requesters 1 and 0 valid -> requester 0 granted first.
- Randomized: 1000 random a/b across random valid/res_ready patterns -> every result matches a*b and the ID; no request is lost or duplicated; no starvation beyond 4 grants.

Source files
------------

// File: rtl/frac_mul_sched.sv
// rtl/frac_mul_sched.sv - round-robin scheduler sharing one iterative shift-add fractional multiplier
module frac_mul_sched #(
  parameter int NUM_REQ = 4,
  parameter int A_W     = 8,
  parameter int B_W     = 16,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*A_W-1:0]   req_a,
  input  logic [NUM_REQ*B_W-1:0]   req_b,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [A_W+B_W-1:0]       res_p,
  output logic [ID_W-1:0]          res_id,
  output logic                     busy
);

  localparam int P_W   = A_W + B_W;
  localparam int CNT_W = (A_W > 1) ? $clog2(A_W) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_HOLD
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [ID_W-1:0]  last_grant;
  logic [ID_W-1:0]  grant_id;
  logic             grant_found;
  logic [A_W-1:0]   a_reg;
  logic [P_W-1:0]   b_reg;
  logic [P_W-1:0]   acc;
  logic [CNT_W-1:0] cnt;

  // Rotating search starting one past the previous winner.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_found && req_valid[(int'(last_grant) + 1 + i) % NUM_REQ]) begin
        grant_found = 1'b1;
        grant_id    = ID_W'((int'(last_grant) + 1 + i) % NUM_REQ);
      end
    end
  end

  always_comb begin
    state_nx  = state;
    req_ready = '0;
    case (state)
      S_IDLE: begin
        if (grant_found) begin
          req_ready[grant_id] = rst_n;
          state_nx            = S_MUL;
        end
      end
      S_MUL: begin
        if (cnt == CNT_W'(A_W - 1)) state_nx = S_HOLD;
      end
      S_HOLD: begin
        if (res_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Datapath: one multiplier bit per MUL cycle, LSB first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg      <= '0;
      b_reg      <= '0;
      acc        <= '0;
      cnt        <= '0;
      res_id     <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_found) begin
            a_reg      <= req_a[grant_id*A_W +: A_W];
            b_reg      <= P_W'(req_b[grant_id*B_W +: B_W]);
            acc        <= '0;
            cnt        <= '0;
            res_id     <= grant_id;
            last_grant <= grant_id;
          end
        end
        S_MUL: begin
          if (a_reg[0]) acc <= acc + b_reg;
          a_reg <= a_reg >> 1;
          b_reg <= b_reg << 1;
          cnt   <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign res_valid = (state == S_HOLD);
  assign busy      = (state != S_IDLE);
  assign res_p     = acc;

endmodule
